// File: rtl/controle_diferenca.sv
// Round-robin sequencer sharing one external |A-B| unit among N_REQ requesters.
// One operand pair in flight at a time; the result is returned tagged with the owner's index.
module controle_diferenca #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         dif_a,
  output logic [WIDTH-1:0]         dif_b,
  input  logic [WIDTH-1:0]         dif_s,
  input  logic                     dif_sinal,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_s,
  output logic                     res_sinal,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [ID_W:0]   NR   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ-1);

  state_t                        state;
  logic [ID_W-1:0]               ptr, sel, nxt_ptr;
  logic [ID_W:0]                 cand;
  logic [N_REQ-1:0][WIDTH-1:0]   a_v, b_v;

  assign a_v = a_in;
  assign b_v = b_in;

  // Scan from the highest offset down so the closest asserted req to ptr wins.
  always_comb begin
    sel  = ptr;
    cand = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (req[cand[ID_W-1:0]]) sel = cand[ID_W-1:0];
    end
  end

  assign nxt_ptr = (res_id == LAST) ? '0 : res_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      dif_a     <= '0;
      dif_b     <= '0;
      res_valid <= 1'b0;
      res_s     <= '0;
      res_sinal <= 1'b0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: if (|req) begin
          dif_a  <= a_v[sel];
          dif_b  <= b_v[sel];
          gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          res_id <= sel;
          busy   <= 1'b1;
          state  <= EXEC;
        end
        // Operands have been stable for the whole cycle; sample the unit's output.
        EXEC: begin
          res_s     <= dif_s;
          res_sinal <= dif_sinal;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          ptr       <= nxt_ptr;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_diferenca.sv
// Bench for controle_diferenca: models the shared |A-B| unit and scoreboards tagged results.
module tb_controle_diferenca;
  localparam int N = 4, W = 4, IW = 2;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a_in = '0, b_in = '0;
  logic [N-1:0]     gnt;
  logic [W-1:0]     dif_a, dif_b, dif_s, res_s;
  logic             dif_sinal, res_valid, res_sinal, busy;
  logic             res_ready = 1'b0;
  logic [IW-1:0]    res_id;

  typedef struct { logic [IW-1:0] id; logic [W-1:0] s; logic sinal; } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [N-1:0] one = 4'b0001;

  controle_diferenca #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .dif_a(dif_a), .dif_b(dif_b), .dif_s(dif_s), .dif_sinal(dif_sinal),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_sinal(res_sinal),
    .res_id(res_id), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared difference unit beside the block.
  assign dif_s     = (dif_a >= dif_b) ? dif_a - dif_b : dif_b - dif_a;
  assign dif_sinal = dif_a < dif_b;

  function automatic exp_t mk(input logic [IW-1:0] id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id    = id;
    e.s     = (a > b) ? a - b : b - a;
    e.sinal = (a < b);
    return e;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0; req = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({gnt, res_valid, res_s, res_sinal, res_id, dif_a, dif_b, busy} !== '0) begin
      n_err++; $display("FAIL rst_state got gnt=%b v=%b s=%0d sg=%b id=%0d a=%0d b=%0d busy=%b exp all 0",
        gnt, res_valid, res_s, res_sinal, res_id, dif_a, dif_b, busy);
    end
    rst_n = 1'b1;
    set_op(0, 4'd3, 4'd9);
    req = 4'b0001;
    @(negedge clk);
    n_vec++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_exec got gnt=%b busy=%b exp 0001/1", gnt, busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt, res_valid, res_s, res_sinal, res_id, dif_a, dif_b, busy} !== '0) begin
      n_err++; $display("FAIL rst_async got gnt=%b v=%b a=%0d b=%0d busy=%b exp all 0",
        gnt, res_valid, dif_a, dif_b, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(0, 4'd3, 4'd9));
    for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
    n_vec++;
    if (gnt !== 4'b0001 || dif_a !== 4'd3 || dif_b !== 4'd9) begin
      n_err++; $display("FAIL rst_gnt got gnt=%b a=%0d b=%0d exp 0001 3 9", gnt, dif_a, dif_b);
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if (gnt !== '0) begin
      n_err++; $display("FAIL rst_gnt_pulse got %b exp 0000", gnt);
    end
    e = sb.pop_front();
    n_vec++;
    if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id) begin
      n_err++; $display("FAIL rst_res got v=%b s=%0d sg=%b id=%0d exp 1 %0d %b %0d",
        res_valid, res_s, res_sinal, res_id, e.s, e.sinal, e.id);
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_done got v=%b busy=%b exp 0 0", res_valid, busy);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    exp_t e;
    logic [W-1:0] ra[N], rb[N];
    int last;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i] = W'(i*3 + 1);
      rb[i] = W'(14 - i*4);
      set_op(i, ra[i], rb[i]);
    end
    for (int k = 0; k < 5; k++) sb.push_back(mk(IW'(k % N), ra[k % N], rb[k % N]));
    res_ready = 1'b1;
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
      e = sb[0];
      n_vec++;
      if (gnt !== (one << e.id)) begin
        n_err++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, one << e.id);
      end
      if (k > 0) begin
        n_vec++;
        if (cyc - last != 3) begin
          n_err++; $display("FAIL rr_period[%0d] got %0d exp 3", k, cyc - last);
        end
      end
      last = cyc;
      if (k == 4) req = '0;
      for (int t = 0; t < 12 && res_valid !== 1'b1; t++) @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id) begin
        n_err++; $display("FAIL rr_res[%0d] got v=%b s=%0d sg=%b id=%0d exp 1 %0d %b %0d",
          k, res_valid, res_s, res_sinal, res_id, e.s, e.sinal, e.id);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    exp_t e;
    res_ready = 1'b0;
    set_op(1, 4'd12, 4'd5);
    sb.push_back(mk(1, 4'd12, 4'd5));
    req = 4'b0010;
    for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
    n_vec++;
    if (gnt !== 4'b0010) begin
      n_err++; $display("FAIL bp_gnt got %b exp 0010", gnt);
    end
    req = '0;
    for (int t = 0; t < 12 && res_valid !== 1'b1; t++) @(negedge clk);
    e = sb.pop_front();
    req = 4'b1111;
    set_op(1, 4'd0, 4'd0);
    set_op(0, 4'd9, 4'd9);
    for (int j = 0; j < 10; j++) begin
      n_vec++;
      if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id ||
          gnt !== '0 || dif_a !== 4'd12) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b s=%0d sg=%b id=%0d gnt=%b a=%0d exp 1 %0d %b %0d 0000 12",
          j, res_valid, res_s, res_sinal, res_id, gnt, dif_a, e.s, e.sinal, e.id);
      end
      @(negedge clk);
    end
    req = '0;
    res_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_done got v=%b busy=%b exp 0 0", res_valid, busy);
    end
  endtask

  task automatic test_isolation;
    exp_t e;
    res_ready = 1'b1;
    set_op(3, 4'd10, 4'd13);
    sb.push_back(mk(3, 4'd10, 4'd13));
    req = 4'b1000;
    for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
    n_vec++;
    if (gnt !== 4'b1000) begin
      n_err++; $display("FAIL iso_gnt got %b exp 1000", gnt);
    end
    req = '0;
    set_op(3, 4'd1, 4'd2);
    #1;
    n_vec++;
    if (dif_a !== 4'd10 || dif_b !== 4'd13) begin
      n_err++; $display("FAIL iso_dif got a=%0d b=%0d exp 10 13", dif_a, dif_b);
    end
    for (int t = 0; t < 12 && res_valid !== 1'b1; t++) @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id) begin
      n_err++; $display("FAIL iso_res got v=%b s=%0d sg=%b id=%0d exp 1 %0d %b %0d",
        res_valid, res_s, res_sinal, res_id, e.s, e.sinal, e.id);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary;
    exp_t e;
    logic [W-1:0] ta[3], tb[3];
    ta[0] = 4'd15; tb[0] = 4'd0;
    ta[1] = 4'd0;  tb[1] = 4'd15;
    ta[2] = 4'd7;  tb[2] = 4'd7;
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(2, ta[k], tb[k]);
      sb.push_back(mk(2, ta[k], tb[k]));
      req = 4'b0100;
      for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
      n_vec++;
      if (gnt !== 4'b0100) begin
        n_err++; $display("FAIL bnd_gnt[%0d] got %b exp 0100", k, gnt);
      end
      req = '0;
      for (int t = 0; t < 12 && res_valid !== 1'b1; t++) @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id) begin
        n_err++; $display("FAIL bnd_res[%0d] got v=%b s=%0d sg=%b id=%0d exp 1 %0d %b %0d",
          k, res_valid, res_s, res_sinal, res_id, e.s, e.sinal, e.id);
      end
      @(negedge clk);
      n_vec++;
      if (res_valid !== 1'b0) begin
        n_err++; $display("FAIL bnd_done[%0d] got v=%b exp 0", k, res_valid);
      end
    end
  endtask

  task automatic test_ptr_wrap;
    exp_t e;
    res_ready = 1'b1;
    set_op(0, 4'd5, 4'd1);
    set_op(2, 4'd2, 4'd8);
    sb.push_back(mk(0, 4'd5, 4'd1));
    sb.push_back(mk(2, 4'd2, 4'd8));
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 12 && gnt === '0; t++) @(negedge clk);
      e = sb[0];
      n_vec++;
      if (gnt !== (one << e.id)) begin
        n_err++; $display("FAIL wrap_gnt[%0d] got %b exp %b", k, gnt, one << e.id);
      end
      req[e.id] = 1'b0;
      for (int t = 0; t < 12 && res_valid !== 1'b1; t++) @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (res_valid !== 1'b1 || res_s !== e.s || res_sinal !== e.sinal || res_id !== e.id) begin
        n_err++; $display("FAIL wrap_res[%0d] got v=%b s=%0d sg=%b id=%0d exp 1 %0d %b %0d",
          k, res_valid, res_s, res_sinal, res_id, e.s, e.sinal, e.id);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_isolation();
    test_boundary();
    test_ptr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
